cvt_wb_stage: RTL and testbench

//  Writeback stage directly downstream of the int/float convert unit (int_float_cvt).

---
 rtl/cvt_pkg.sv | 33 +++
 rtl/cvt_wb_fifo.sv | 73 +++++++
 rtl/cvt_wb_stage.sv | 128 ++++++++++++
 tb/tb_cvt_wb_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvt_pkg.sv
// Shared types for the convert-unit writeback stage: the entry kind, the queued
// entry record, and the push-time kind decode.
package cvt_pkg;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_INT  = 2'd1,
        WB_FP   = 2'd2
    } wb_kind_e;

    typedef struct packed {
        wb_kind_e    kind;
        logic [4:0]  waddr;
        logic [31:0] data;
    } wb_entry_t;

    localparam logic [4:0] X0_ADDR = 5'd0;

    // FP wins when both enables are set; an INT write to x0 is dropped at push time.
    function automatic wb_kind_e decode_kind(input logic       fp_en,
                                             input logic       int_en,
                                             input logic [4:0] waddr);
        wb_kind_e kind;
        kind = WB_NONE;
        if (fp_en) begin
            kind = WB_FP;
        end else if (int_en && (waddr != X0_ADDR)) begin
            kind = WB_INT;
        end
        return kind;
    endfunction

endpackage

// File: rtl/cvt_wb_fifo.sv
// In-order circular buffer of writeback entries. It exposes the head entry and
// per-slot kind/address/valid vectors so the stage can do its hazard lookup.
module cvt_wb_fifo
    import cvt_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  wb_entry_t                   push_entry,
    input  logic                        pop,
    output wb_entry_t                   head,
    output logic [PTR_W:0]              count,
    output logic [DEPTH-1:0]            ent_valid,
    output logic [DEPTH-1:0][1:0]       ent_kind,
    output logic [DEPTH-1:0][4:0]       ent_waddr
);

    wb_entry_t           mem_reg [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [PTR_W:0]      count_reg;
    logic [PTR_W:0]      count_next;

    // Entry storage carries no reset; slot validity comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= push_entry;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + (PTR_W + 1)'(1);
            2'b01:   count_next = count_reg - (PTR_W + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

    // A slot is live when its distance from the read pointer is below the count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] offset;
            assign offset        = PTR_W'(gi) - rd_ptr_reg;
            assign ent_valid[gi] = ({1'b0, offset} < count_reg);
            assign ent_kind[gi]  = mem_reg[gi].kind;
            assign ent_waddr[gi] = mem_reg[gi].waddr;
        end
    endgenerate

endmodule

// File: rtl/cvt_wb_stage.sv
// Writeback stage after the int/float converter: queues results in order, drains them
// to the INT or shared FP write port, and answers decode's pending-write lookups.
module cvt_wb_stage
    import cvt_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16,
    localparam int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_wb_fp_en,
    input  logic               in_wb_int_en,
    input  logic [4:0]         in_waddr,
    output logic               int_we,
    output logic [4:0]         int_waddr,
    output logic [31:0]        int_wdata,
    input  logic               fp_port_busy,
    output logic               fp_we,
    output logic [4:0]         fp_waddr,
    output logic [31:0]        fp_wdata,
    input  logic [4:0]         chk_addr,
    input  logic               chk_is_fp,
    output logic               chk_hit,
    output logic [OCC_W-1:0]   occupancy,
    output logic [CNT_W-1:0]   fp_stall_cnt
);

    wb_entry_t               push_entry;
    wb_entry_t               head;
    logic                    push;
    logic                    pop;
    logic                    head_valid;
    logic                    fp_blocked;
    logic [DEPTH-1:0]        ent_valid;
    logic [DEPTH-1:0][1:0]   ent_kind;
    logic [DEPTH-1:0][4:0]   ent_waddr;
    logic [DEPTH-1:0]        hit_vec;
    logic [1:0]              want_kind;
    logic [CNT_W-1:0]        stall_cnt_reg;

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
    assign in_ready   = (occupancy < OCC_W'(DEPTH));
    assign push       = in_valid && in_ready;
    assign head_valid = (occupancy != '0);

    always_comb begin
        push_entry       = '0;
        push_entry.kind  = decode_kind(in_wb_fp_en, in_wb_int_en, in_waddr);
        push_entry.waddr = in_waddr;
        push_entry.data  = in_data;
    end

    cvt_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (occupancy),
        .ent_valid  (ent_valid),
        .ent_kind   (ent_kind),
        .ent_waddr  (ent_waddr)
    );

    always_comb begin
        int_we     = 1'b0;
        int_waddr  = '0;
        int_wdata  = '0;
        fp_we      = 1'b0;
        fp_waddr   = '0;
        fp_wdata   = '0;
        pop        = 1'b0;
        fp_blocked = 1'b0;
        if (head_valid) begin
            case (head.kind)
                WB_INT: begin
                    int_we    = 1'b1;
                    int_waddr = head.waddr;
                    int_wdata = head.data;
                    pop       = 1'b1;
                end
                WB_FP: begin
                    // The FPU pipe owns the port when busy; the head holds in place.
                    if (fp_port_busy) begin
                        fp_blocked = 1'b1;
                    end else begin
                        fp_we    = 1'b1;
                        fp_waddr = head.waddr;
                        fp_wdata = head.data;
                        pop      = 1'b1;
                    end
                end
                default: pop = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (fp_blocked && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign fp_stall_cnt = stall_cnt_reg;

    // Popping entries still count as pending, which keeps the lookup conservative.
    assign want_kind = chk_is_fp ? WB_FP : WB_INT;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit_vec[gi] = ent_valid[gi]
                              && (ent_kind[gi] == want_kind)
                              && (ent_waddr[gi] == chk_addr);
        end
    endgenerate

    assign chk_hit = (|hit_vec) && !(!chk_is_fp && (chk_addr == X0_ADDR));

endmodule

// File: tb/tb_cvt_wb_stage.sv
// Directed bench for cvt_wb_stage: a table of single-entry transactions plus
// hand-written stall, ordering, saturation, async-reset and wrap sequences.
module tb_cvt_wb_stage;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_data;
    logic               in_wb_fp_en;
    logic               in_wb_int_en;
    logic [4:0]         in_waddr;
    logic               int_we;
    logic [4:0]         int_waddr;
    logic [31:0]        int_wdata;
    logic               fp_port_busy;
    logic               fp_we;
    logic [4:0]         fp_waddr;
    logic [31:0]        fp_wdata;
    logic [4:0]         chk_addr;
    logic               chk_is_fp;
    logic               chk_hit;
    logic [OCC_W-1:0]   occupancy;
    logic [CNT_W-1:0]   fp_stall_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    cvt_wb_stage #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_wb_fp_en  (in_wb_fp_en),
        .in_wb_int_en (in_wb_int_en),
        .in_waddr     (in_waddr),
        .int_we       (int_we),
        .int_waddr    (int_waddr),
        .int_wdata    (int_wdata),
        .fp_port_busy (fp_port_busy),
        .fp_we        (fp_we),
        .fp_waddr     (fp_waddr),
        .fp_wdata     (fp_wdata),
        .chk_addr     (chk_addr),
        .chk_is_fp    (chk_is_fp),
        .chk_hit      (chk_hit),
        .occupancy    (occupancy),
        .fp_stall_cnt (fp_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        fp_en;
        logic        int_en;
        logic [4:0]  waddr;
        logic [31:0] data;
        logic [4:0]  c_addr;
        logic        c_fp;
        logic        e_int_we;
        logic        e_fp_we;
        logic        e_hit;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic fp_en, input logic int_en,
                         input logic [4:0] waddr, input logic [31:0] data);
        in_valid     = 1'b1;
        in_wb_fp_en  = fp_en;
        in_wb_int_en = int_en;
        in_waddr     = waddr;
        in_data      = data;
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_wb_fp_en  = 1'b0;
        in_wb_int_en = 1'b0;
        in_waddr     = '0;
        fp_port_busy = 1'b0;
        chk_addr     = 5'd5;
        chk_is_fp    = 1'b0;

        vecs[0] = '{"int_x5",     1'b0, 1'b1, 5'd5,  32'h0000002A, 5'd5,  1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{"int_x0",     1'b0, 1'b1, 5'd0,  32'h00000055, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{"none",       1'b0, 1'b0, 5'd4,  32'h12345678, 5'd4,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{"both_en",    1'b1, 1'b1, 5'd9,  32'h40490FDB, 5'd9,  1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{"fp_f31",     1'b1, 1'b0, 5'd31, 32'hFFFFFFFF, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{"int_x12",    1'b0, 1'b1, 5'd12, 32'h80000000, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset state while rst_n is held low
        #12;
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_int_we", 32'(int_we), 32'd0);
        check("rst_fp_we", 32'(fp_we), 32'd0);
        check("rst_cnt", 32'(fp_stall_cnt), 32'd0);
        check("rst_hit", 32'(chk_hit), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single-entry transactions on an empty buffer with the FP port free
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].fp_en, vecs[i].int_en, vecs[i].waddr, vecs[i].data);
            chk_addr  = vecs[i].c_addr;
            chk_is_fp = vecs[i].c_fp;
            sample();
            check({vecs[i].name, "_ready"}, 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            sample();
            check({vecs[i].name, "_int_we"}, 32'(int_we), 32'(vecs[i].e_int_we));
            check({vecs[i].name, "_int_waddr"}, 32'(int_waddr), vecs[i].e_int_we ? 32'(vecs[i].waddr) : 32'd0);
            check({vecs[i].name, "_int_wdata"}, int_wdata, vecs[i].e_int_we ? vecs[i].data : 32'd0);
            check({vecs[i].name, "_fp_we"}, 32'(fp_we), 32'(vecs[i].e_fp_we));
            check({vecs[i].name, "_fp_waddr"}, 32'(fp_waddr), vecs[i].e_fp_we ? 32'(vecs[i].waddr) : 32'd0);
            check({vecs[i].name, "_fp_wdata"}, fp_wdata, vecs[i].e_fp_we ? vecs[i].data : 32'd0);
            check({vecs[i].name, "_hit"}, 32'(chk_hit), 32'(vecs[i].e_hit));
            check({vecs[i].name, "_occ1"}, 32'(occupancy), 32'd1);
            tick();
            sample();
            check({vecs[i].name, "_occ0"}, 32'(occupancy), 32'd0);
            check({vecs[i].name, "_idle_we"}, 32'(int_we | fp_we), 32'd0);
            $display("txn %0d %s waddr=%0d data=0x%08h", i, vecs[i].name, vecs[i].waddr, vecs[i].data);
            tick();
        end

        // FP head blocked for 4 cycles, then released
        fp_port_busy = 1'b1;
        chk_addr     = 5'd3;
        chk_is_fp    = 1'b1;
        drive(1'b1, 1'b0, 5'd3, 32'h3F800000);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            check($sformatf("stall_fp_we_%0d", k), 32'(fp_we), 32'd0);
            check($sformatf("stall_hit_%0d", k), 32'(chk_hit), 32'd1);
            tick();
        end
        fp_port_busy = 1'b0;
        sample();
        check("stall_cnt4", 32'(fp_stall_cnt), 32'd4);
        check("stall_rel_we", 32'(fp_we), 32'd1);
        check("stall_rel_waddr", 32'(fp_waddr), 32'd3);
        check("stall_rel_wdata", fp_wdata, 32'h3F800000);
        tick();
        sample();
        check("stall_occ0", 32'(occupancy), 32'd0);
        $display("txn stall fp f3 released after 4 busy cycles");
        tick();

        // INT entry queued behind a stalled FP head
        fp_port_busy = 1'b1;
        chk_addr     = 5'd7;
        chk_is_fp    = 1'b0;
        drive(1'b1, 1'b0, 5'd2, 32'h40000000);
        tick();
        drive(1'b0, 1'b1, 5'd7, 32'h00000077);
        tick();
        in_valid = 1'b0;
        sample();
        check("order_ready_full", 32'(in_ready), 32'd0);
        check("order_occ2", 32'(occupancy), 32'd2);
        check("order_int_wait", 32'(int_we), 32'd0);
        check("order_hit_x7", 32'(chk_hit), 32'd1);
        tick();
        fp_port_busy = 1'b0;
        sample();
        check("order_fp_we", 32'(fp_we), 32'd1);
        check("order_fp_waddr", 32'(fp_waddr), 32'd2);
        check("order_int_still0", 32'(int_we), 32'd0);
        check("order_cnt6", 32'(fp_stall_cnt), 32'd6);
        tick();
        sample();
        check("order_int_we", 32'(int_we), 32'd1);
        check("order_int_waddr", 32'(int_waddr), 32'd7);
        check("order_int_wdata", int_wdata, 32'h00000077);
        check("order_fp_we0", 32'(fp_we), 32'd0);
        tick();
        sample();
        check("order_occ0", 32'(occupancy), 32'd0);
        $display("txn order fp f2 then int x7");
        tick();

        // Fill to DEPTH under stall, saturate the counter, then async reset mid-stall
        fp_port_busy = 1'b1;
        drive(1'b1, 1'b0, 5'd20, 32'hAAAA0001);
        tick();
        drive(1'b1, 1'b0, 5'd21, 32'hAAAA0002);
        tick();
        in_valid = 1'b0;
        repeat (18) tick();
        chk_addr  = 5'd21;
        chk_is_fp = 1'b1;
        sample();
        check("sat_cnt", 32'(fp_stall_cnt), 32'd15);
        check("sat_occ2", 32'(occupancy), 32'd2);
        check("sat_hit_f21", 32'(chk_hit), 32'd1);
        tick();
        fp_port_busy = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_occ", 32'(occupancy), 32'd0);
        check("arst_fp_we", 32'(fp_we), 32'd0);
        check("arst_int_we", 32'(int_we), 32'd0);
        check("arst_cnt", 32'(fp_stall_cnt), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_hit", 32'(chk_hit), 32'd0);
        tick();
        rst_n = 1'b1;
        sample();
        check("arst_occ_after", 32'(occupancy), 32'd0);
        $display("txn async reset with full buffer");
        tick();

        // Back-to-back pushes across 3*DEPTH slots exercise pointer wrap
        chk_is_fp = 1'b0;
        drive(1'b0, 1'b1, 5'd10, 32'h00000100);
        tick();
        for (int k = 0; k < 3 * DEPTH; k++) begin
            if (k < 3 * DEPTH - 1) begin
                drive(1'b0, 1'b1, 5'(11 + k), 32'h00000101 + 32'(k));
            end else begin
                in_valid = 1'b0;
            end
            chk_addr = 5'(10 + k);
            sample();
            check($sformatf("wrap_int_we_%0d", k), 32'(int_we), 32'd1);
            check($sformatf("wrap_waddr_%0d", k), 32'(int_waddr), 32'(10 + k));
            check($sformatf("wrap_wdata_%0d", k), int_wdata, 32'h00000100 + 32'(k));
            check($sformatf("wrap_occ_%0d", k), 32'(occupancy), 32'd1);
            check($sformatf("wrap_hit_%0d", k), 32'(chk_hit), 32'd1);
            $display("txn wrap %0d int x%0d", k, 10 + k);
            tick();
        end
        sample();
        check("wrap_occ_end", 32'(occupancy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
